// File: rtl/udp_tx_sched_if.sv
// Bundle between the transmit scheduler (master) and its requesters,
// FIFO writer and MAC transmit controls (slave).
interface udp_tx_sched_if;
    // req_*/done_*: a level request is held until its one-cycle done pulse.
    // fs_*/fd_*: fs is held until fd is sampled high, then fs drops, and
    // the stage only ends once fd has returned low.
    logic        req_data;
    logic        req_ack;
    logic        done_data;
    logic        done_ack;
    logic        fs_fw;
    logic        fd_fw;
    logic        fs_udp_tx;
    logic        fd_udp_tx;
    logic [15:0] tx_len;
    logic [7:0]  fifo_part;
    logic        busy;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        input  req_data, req_ack, fd_fw, fd_udp_tx,
        output done_data, done_ack, fs_fw, fs_udp_tx, tx_len, fifo_part,
               busy, err, err_cnt
    );

    modport slave (
        output req_data, req_ack, fd_fw, fd_udp_tx,
        input  done_data, done_ack, fs_fw, fs_udp_tx, tx_len, fifo_part,
               busy, err, err_cnt
    );
endinterface

// File: rtl/udp_tx_sched.sv
// Transmit scheduler: round-robin between data and ack frame requests, then
// runs FIFO fill followed by MAC send, with timeout recovery and a frame gap.
module udp_tx_sched #(
    parameter logic [15:0] DATA_LEN   = 16'h0020,
    parameter logic [15:0] ACK_LEN    = 16'h0008,
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter logic [7:0]  GAP_CYCLES = 8'd8
) (
    input  logic              clk,
    input  logic              rst,
    udp_tx_sched_if.master    bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_FLDN = 3'd2,
        S_SEND = 3'd3,
        S_SDDN = 3'd4,
        S_GAP  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t      state, state_nx;
    logic [15:0] timer;
    logic [7:0]  gap_cnt;
    logic [6:0]  data_seq, ack_seq;
    logic        last_ack;
    logic        cur_ack;

    logic        grant, gnt_ack, timer_hit, gap_done;
    logic        fs_fw_d, fs_udp_tx_d, busy_d;
    logic        done_data_d, done_ack_d, err_entry;

    assign dbg_state = state;

    // Both pending: the kind not granted last wins; last_ack resets to 0 so ack goes first.
    assign grant     = (state == S_IDLE) && (bus.req_data || bus.req_ack);
    assign gnt_ack   = bus.req_ack && (!bus.req_data || !last_ack);
    assign timer_hit = (timer == TIMEOUT - 16'd1);
    assign gap_done  = (({1'b0, gap_cnt} + 9'd1) >= {1'b0, GAP_CYCLES});

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.req_data || bus.req_ack) state_nx = S_FILL;
            S_FILL: begin
                if (bus.fd_fw)       state_nx = S_FLDN;
                else if (timer_hit)  state_nx = S_ERR;
            end
            S_FLDN: if (!bus.fd_fw) state_nx = S_SEND;
            S_SEND: begin
                if (bus.fd_udp_tx)   state_nx = S_SDDN;
                else if (timer_hit)  state_nx = S_ERR;
            end
            S_SDDN: if (!bus.fd_udp_tx) state_nx = S_GAP;
            S_GAP:  if (gap_done) state_nx = S_IDLE;
            S_ERR:  if (!bus.fd_fw && !bus.fd_udp_tx) state_nx = S_GAP;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        fs_fw_d     = (state_nx == S_FILL);
        fs_udp_tx_d = (state_nx == S_SEND);
        busy_d      = (state_nx != S_IDLE);
        done_data_d = (state == S_SDDN) && (state_nx == S_GAP) && !cur_ack;
        done_ack_d  = (state == S_SDDN) && (state_nx == S_GAP) && cur_ack;
        err_entry   = (state_nx == S_ERR) && (state != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fs_fw     <= 1'b0;
            bus.fs_udp_tx <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done_data <= 1'b0;
            bus.done_ack  <= 1'b0;
            bus.tx_len    <= 16'h0000;
            bus.fifo_part <= 8'h00;
            bus.err       <= 1'b0;
            bus.err_cnt   <= 8'h00;
            timer         <= 16'h0000;
            gap_cnt       <= 8'h00;
            data_seq      <= 7'd0;
            ack_seq       <= 7'd0;
            last_ack      <= 1'b0;
            cur_ack       <= 1'b0;
        end else begin
            bus.fs_fw     <= fs_fw_d;
            bus.fs_udp_tx <= fs_udp_tx_d;
            bus.busy      <= busy_d;
            bus.done_data <= done_data_d;
            bus.done_ack  <= done_ack_d;

            // Descriptors are frozen from grant until the next grant.
            if (grant) begin
                cur_ack       <= gnt_ack;
                last_ack      <= gnt_ack;
                bus.tx_len    <= gnt_ack ? ACK_LEN : DATA_LEN;
                bus.fifo_part <= gnt_ack ? {1'b1, ack_seq} : {1'b0, data_seq};
            end

            if ((state_nx == S_FILL && state != S_FILL) ||
                (state_nx == S_SEND && state != S_SEND))
                timer <= 16'h0000;
            else if (state == S_FILL || state == S_SEND)
                timer <= timer + 16'd1;

            if (state != S_GAP) gap_cnt <= 8'h00;
            else                gap_cnt <= gap_cnt + 8'd1;

            if (done_data_d) data_seq <= data_seq + 7'd1;
            if (done_ack_d)  ack_seq  <= ack_seq + 7'd1;

            if (err_entry) begin
                bus.err <= 1'b1;
                if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched: frame descriptors are scoreboarded at
// every grant, and timing, round-robin, wrap, timeout and reset are checked.
module tb_udp_tx_sched;

    localparam logic [15:0] TMO  = 16'd40;
    localparam int          W    = 24;
    localparam logic [15:0] DLEN = 16'h0020;
    localparam logic [15:0] ALEN = 16'h0008;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    udp_tx_sched_if bus();

    udp_tx_sched #(
        .DATA_LEN(DLEN), .ACK_LEN(ALEN), .TIMEOUT(TMO), .GAP_CYCLES(8'd8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    bit  have_exp = 1'b0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  grant_cnt = 0, done_data_cnt = 0, done_ack_cnt = 0;
    int  grant_cyc = 0, send_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic prev_fs_fw = 1'b0, prev_fs_tx = 1'b0, prev_err = 1'b0;

    // ---------------- responder drivers ----------------
    int fw_delay = 1, mac_delay = 1;
    bit fw_en = 1'b1, mac_en = 1'b1;

    initial begin
        int c;
        c = 0;
        bus.fd_fw = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fs_fw && fw_en) begin
                c++;
                if (c >= fw_delay) bus.fd_fw = 1'b1;
            end else begin
                c = 0;
                bus.fd_fw = 1'b0;
            end
        end
    end

    initial begin
        int c;
        c = 0;
        bus.fd_udp_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fs_udp_tx && mac_en) begin
                c++;
                if (c >= mac_delay) bus.fd_udp_tx = 1'b1;
            end else begin
                c = 0;
                bus.fd_udp_tx = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.fs_fw && !prev_fs_fw) begin
            grant_cnt++;
            grant_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                have_exp = 1'b0;
                $display("FAIL grant_unexpected: got len=%h part=%h, required no grant", bus.tx_len, bus.fifo_part);
            end else begin
                cur_exp  = exp_q.pop_front();
                have_exp = 1'b1;
                if ({bus.tx_len, bus.fifo_part} !== cur_exp) begin
                    n_fail++;
                    $display("FAIL grant_desc: got len=%h part=%h, required len=%h part=%h",
                             bus.tx_len, bus.fifo_part, cur_exp[23:8], cur_exp[7:0]);
                end
            end
        end else if (bus.busy && have_exp) begin
            n_checks++;
            if ({bus.tx_len, bus.fifo_part} !== cur_exp) begin
                n_fail++;
                $display("FAIL desc_stable: got len=%h part=%h, required len=%h part=%h",
                         bus.tx_len, bus.fifo_part, cur_exp[23:8], cur_exp[7:0]);
            end
        end
        n_checks++;
        if (bus.fs_fw && bus.fs_udp_tx) begin
            n_fail++;
            $display("FAIL fs_overlap: got fs_fw=1 fs_udp_tx=1, required at most one");
        end
        if (bus.fs_udp_tx && !prev_fs_tx) send_cyc = cyc;
        if (bus.err && !prev_err) err_cyc = cyc;
        if (bus.done_data || bus.done_ack) begin
            done_cyc = cyc;
            n_checks++;
            if ((bus.done_data && bus.done_ack) || !have_exp || (bus.done_ack !== cur_exp[7])) begin
                n_fail++;
                $display("FAIL done_kind: got done_data=%b done_ack=%b, required ack=%b",
                         bus.done_data, bus.done_ack, cur_exp[7]);
            end
            if (bus.done_data) done_data_cnt++;
            if (bus.done_ack)  done_ack_cnt++;
        end
        prev_fs_fw = bus.fs_fw;
        prev_fs_tx = bus.fs_udp_tx;
        prev_err   = bus.err;
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        have_exp = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_data = 1'b0;
        bus.req_ack  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.fs_fw !== 1'b0)     begin n_fail++; $display("FAIL rst_fs_fw: got %b, required 0", bus.fs_fw); end
        n_checks++; if (bus.fs_udp_tx !== 1'b0) begin n_fail++; $display("FAIL rst_fs_udp_tx: got %b, required 0", bus.fs_udp_tx); end
        n_checks++; if (bus.done_data !== 1'b0) begin n_fail++; $display("FAIL rst_done_data: got %b, required 0", bus.done_data); end
        n_checks++; if (bus.done_ack !== 1'b0)  begin n_fail++; $display("FAIL rst_done_ack: got %b, required 0", bus.done_ack); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
        n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL rst_err: got %b, required 0", bus.err); end
        n_checks++; if (bus.err_cnt !== 8'h00)  begin n_fail++; $display("FAIL rst_err_cnt: got %h, required 00", bus.err_cnt); end
        n_checks++; if (bus.tx_len !== 16'h0000) begin n_fail++; $display("FAIL rst_tx_len: got %h, required 0000", bus.tx_len); end
        n_checks++; if (bus.fifo_part !== 8'h00) begin n_fail++; $display("FAIL rst_fifo_part: got %h, required 00", bus.fifo_part); end
        n_checks++; if (dbg_state !== 3'd0)     begin n_fail++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got busy=%b, required 0", bus.busy); end
    endtask

    task automatic test_single_data();
        int d0;
        fw_delay = 5;
        mac_delay = 20;
        d0 = done_data_cnt;
        exp_q.push_back({DLEN, 8'h00});
        bus.req_data = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (done_data_cnt > d0) break;
            tick();
        end
        bus.req_data = 1'b0;
        n_checks++; if (done_data_cnt != d0 + 1) begin n_fail++; $display("FAIL single_done: got %0d pulses, required 1", done_data_cnt - d0); end
        n_checks++; if (send_cyc - grant_cyc != 6) begin n_fail++; $display("FAIL single_fill_to_send: got %0d cycles, required 6", send_cyc - grant_cyc); end
        n_checks++; if (done_cyc - send_cyc != 21) begin n_fail++; $display("FAIL single_send_to_done: got %0d cycles, required 21", done_cyc - send_cyc); end
        repeat (7) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_gap_busy: got %b, required 1", bus.busy); end
        repeat (2) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after_gap: got %b, required 0", bus.busy); end
        n_checks++; if (done_data_cnt != d0 + 1) begin n_fail++; $display("FAIL single_no_extra_done: got %0d pulses, required 1", done_data_cnt - d0); end
    endtask

    task automatic test_round_robin();
        int d0, a0, g0, dc;
        bit ok;
        do_reset();
        fw_delay = 2;
        mac_delay = 3;
        d0 = done_data_cnt; a0 = done_ack_cnt; g0 = grant_cnt;
        exp_q.push_back({ALEN, 8'h80});
        exp_q.push_back({DLEN, 8'h00});
        exp_q.push_back({ALEN, 8'h81});
        exp_q.push_back({DLEN, 8'h01});
        bus.req_data = 1'b1;
        bus.req_ack  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if ((done_data_cnt - d0) + (done_ack_cnt - a0) > f) begin ok = 1'b1; break; end
                tick();
            end
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rr_done_timeout: frame %0d got no done, required done", f); break; end
            dc = done_cyc;
            if (f == 3) begin
                bus.req_data = 1'b0;
                bus.req_ack  = 1'b0;
            end else begin
                for (int k = 0; k < 50; k++) begin
                    if (grant_cnt > g0 + f + 1) break;
                    tick();
                end
                n_checks++;
                if (grant_cyc - dc != 9) begin n_fail++; $display("FAIL rr_gap: got %0d cycles done->grant, required 9", grant_cyc - dc); end
            end
        end
        repeat (15) tick();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_pending: got %0d frames left, required 0", exp_q.size()); end
        n_checks++; if (done_ack_cnt - a0 != 2) begin n_fail++; $display("FAIL rr_ack_count: got %0d, required 2", done_ack_cnt - a0); end
        n_checks++; if (done_data_cnt - d0 != 2) begin n_fail++; $display("FAIL rr_data_count: got %0d, required 2", done_data_cnt - d0); end
    endtask

    task automatic test_seq_wrap();
        int d0;
        logic [6:0] s;
        do_reset();
        fw_delay = 1;
        mac_delay = 1;
        d0 = done_data_cnt;
        for (int i = 0; i < 130; i++) begin
            s = i[6:0];
            exp_q.push_back({DLEN, 1'b0, s});
        end
        bus.req_data = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            if (done_data_cnt >= d0 + 130) break;
            tick();
        end
        bus.req_data = 1'b0;
        repeat (15) tick();
        n_checks++; if (done_data_cnt != d0 + 130) begin n_fail++; $display("FAIL wrap_count: got %0d frames, required 130", done_data_cnt - d0); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_pending: got %0d frames left, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout_send();
        int d0;
        bit ok;
        do_reset();
        fw_delay = 1;
        mac_en = 1'b0;
        d0 = done_data_cnt;
        exp_q.push_back({DLEN, 8'h00});
        bus.req_data = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.err) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_err_set: got err=%b, required 1", bus.err); end
        n_checks++; if (err_cyc - send_cyc != int'(TMO)) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles, required %0d", err_cyc - send_cyc, TMO); end
        n_checks++; if (bus.err_cnt !== 8'h01) begin n_fail++; $display("FAIL tmo_err_cnt: got %h, required 01", bus.err_cnt); end
        n_checks++; if (done_data_cnt != d0) begin n_fail++; $display("FAIL tmo_no_done: got %0d pulses, required 0", done_data_cnt - d0); end
        exp_q.push_back({DLEN, 8'h00});
        mac_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (done_data_cnt > d0) break;
            tick();
        end
        bus.req_data = 1'b0;
        n_checks++; if (done_data_cnt != d0 + 1) begin n_fail++; $display("FAIL tmo_retry_done: got %0d pulses, required 1", done_data_cnt - d0); end
        n_checks++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'h01) begin n_fail++; $display("FAIL tmo_sticky: got err=%b cnt=%h, required 1/01", bus.err, bus.err_cnt); end
        repeat (12) tick();
    endtask

    task automatic test_err_saturate();
        int g0;
        logic [7:0] exp_cnt;
        bit ok;
        do_reset();
        fw_en = 1'b0;
        g0 = grant_cnt;
        for (int i = 0; i < 300; i++) exp_q.push_back({DLEN, 8'h00});
        bus.req_data = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (grant_cnt > g0 + i) begin ok = 1'b1; break; end
                tick();
            end
            if (ok) begin
                ok = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    if (!bus.fs_fw) begin ok = 1'b1; break; end
                    tick();
                end
            end
            if (i == 299) bus.req_data = 1'b0;
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL sat_wait: timeout %0d never happened, required it", i); bus.req_data = 1'b0; break; end
            exp_cnt = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            n_checks++;
            if (bus.err_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_err_cnt: got %h, required %h", bus.err_cnt, exp_cnt); end
        end
        repeat (15) tick();
        fw_en = 1'b1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle: got busy=%b, required 0", bus.busy); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_rst_mid_send();
        int d0;
        bit ok;
        fw_delay = 1;
        mac_en = 1'b0;
        exp_q.push_back({DLEN, 8'h00});
        bus.req_data = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.fs_udp_tx) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_send: got fs_udp_tx=0, required 1"); end
        repeat (3) tick();
        rst = 1'b1;
        exp_q.push_back({DLEN, 8'h00});
        tick();
        n_checks++; if (bus.fs_udp_tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_fs: got %b, required 0", bus.fs_udp_tx); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", bus.busy); end
        n_checks++; if (bus.err_cnt !== 8'h00)  begin n_fail++; $display("FAIL rstmid_err_cnt: got %h, required 00", bus.err_cnt); end
        n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL rstmid_err: got %b, required 0", bus.err); end
        rst = 1'b0;
        mac_en = 1'b1;
        d0 = done_data_cnt;
        for (int k = 0; k < 200; k++) begin
            if (done_data_cnt > d0) break;
            tick();
        end
        bus.req_data = 1'b0;
        n_checks++; if (done_data_cnt != d0 + 1) begin n_fail++; $display("FAIL rstmid_restart: got %0d pulses, required 1", done_data_cnt - d0); end
        repeat (12) tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        bus.req_data = 1'b0;
        bus.req_ack  = 1'b0;
        test_reset();
        test_single_data();
        test_round_robin();
        test_seq_wrap();
        test_timeout_send();
        test_err_saturate();
        test_rst_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
